// File: rtl/adjust_apply_unit.sv
// Applies the adjust-module correction with a nibble-serial 16-bit add/sub, then shapes result/flags.
// Optional macro ADJ_SINGLE_CYCLE_EN: compute the full 16-bit add/sub in one CALC cycle.
module adjust_apply_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic        cf_in,
    input  logic        af_in,
    input  logic [1:0]  op,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        cf_out,
    output logic        af_out,
    output logic        zf_out,
    output logic        sf_out
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_a, r_b;
    logic        r_cfi, r_afi, r_sub;
    logic [1:0]  r_op;
    logic [15:0] r_result;
    logic        r_cf, r_af, r_zf, r_sf;

    logic [15:0] w_raw, w_shaped;
    logic        w_cout, w_c3, w_last, w_cf, w_af;

`ifdef ADJ_SINGLE_CYCLE_EN
    logic [15:0] w_b_eff;
    logic [16:0] w_full;
    logic [4:0]  w_low;

    always_comb begin
        w_b_eff = r_sub ? ~r_b : r_b;
        w_full  = {1'b0, r_a} + {1'b0, w_b_eff} + {16'b0, r_sub};
        w_low   = {1'b0, r_a[3:0]} + {1'b0, w_b_eff[3:0]} + {4'b0, r_sub};
        w_raw   = w_full[15:0];
        w_cout  = w_full[16];
        w_c3    = w_low[4];
        w_last  = 1'b1;
    end
`else
    logic [1:0]  r_cnt;
    logic        r_carry, r_c3;
    logic [11:0] r_sum;
    logic [3:0]  w_a_n, w_b_n;
    logic [4:0]  w_nsum;

    always_comb begin
        w_a_n = r_a[15:12];
        w_b_n = r_b[15:12];
        case (r_cnt)
            2'd0: begin w_a_n = r_a[3:0];   w_b_n = r_b[3:0];   end
            2'd1: begin w_a_n = r_a[7:4];   w_b_n = r_b[7:4];   end
            2'd2: begin w_a_n = r_a[11:8];  w_b_n = r_b[11:8];  end
            default: ;
        endcase
        if (r_sub) w_b_n = ~w_b_n;
        w_nsum = {1'b0, w_a_n} + {1'b0, w_b_n} + {4'b0, r_carry};
        // Top nibble is consumed straight from the adder on the last CALC cycle.
        w_raw  = {w_nsum[3:0], r_sum};
        w_cout = w_nsum[4];
        w_c3   = r_c3;
        w_last = (r_cnt == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_carry <= 1'b0;
            r_c3    <= 1'b0;
            r_sum   <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_cnt   <= 2'd0;
            r_carry <= sub;
        end else if (r_state == CALC) begin
            r_cnt   <= r_cnt + 2'd1;
            r_carry <= w_nsum[4];
            case (r_cnt)
                2'd0: begin r_sum[3:0] <= w_nsum[3:0]; r_c3 <= w_nsum[4]; end
                2'd1: r_sum[7:4]  <= w_nsum[3:0];
                2'd2: r_sum[11:8] <= w_nsum[3:0];
                default: ;
            endcase
        end
    end
`endif

    // Subtract mode reports borrows, i.e. inverted adder carries.
    always_comb begin
        w_shaped = w_raw;
        w_cf     = w_cout ^ r_sub;
        w_af     = w_c3 ^ r_sub;
        case (r_op)
            2'b10: begin
                w_shaped = {w_raw[15:8], 4'b0000, w_raw[3:0]};
                w_cf     = r_cfi;
                w_af     = r_afi;
            end
            2'b11: begin
                w_shaped = {r_a[15:8], w_raw[7:0]};
                w_cf     = r_cfi;
                w_af     = r_afi;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = CALC;
            CALC:    if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_cfi    <= 1'b0;
            r_afi    <= 1'b0;
            r_op     <= 2'b00;
            r_sub    <= 1'b0;
            r_result <= '0;
            r_cf     <= 1'b0;
            r_af     <= 1'b0;
            r_zf     <= 1'b0;
            r_sf     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_valid) begin
                r_a   <= a_in;
                r_b   <= b_in;
                r_cfi <= cf_in;
                r_afi <= af_in;
                r_op  <= op;
                r_sub <= sub;
            end
            if (r_state == CALC && w_last) begin
                r_result <= w_shaped;
                r_cf     <= w_cf;
                r_af     <= w_af;
                r_zf     <= (w_shaped == 16'h0000);
                r_sf     <= w_shaped[15];
            end
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign cf_out    = r_cf;
    assign af_out    = r_af;
    assign zf_out    = r_zf;
    assign sf_out    = r_sf;

endmodule

// File: tb/tb_adjust_apply_unit.sv
// Directed bench for adjust_apply_unit: arithmetic reference model plus per-cycle output compare.
module tb_adjust_apply_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_in = '0;
    logic [15:0] b_in = '0;
    logic        cf_in = 1'b0;
    logic        af_in = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        cf_out, af_out, zf_out, sf_out;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [19:0] exp_v = '0;

`ifdef ADJ_SINGLE_CYCLE_EN
    localparam int LATENCY = 1;
`else
    localparam int LATENCY = 4;
`endif

    adjust_apply_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .cf_in(cf_in), .af_in(af_in),
        .op(op), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cf_out(cf_out), .af_out(af_out),
        .zf_out(zf_out), .sf_out(sf_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; borrows from magnitude comparison.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cfi, input logic afi,
                                          input logic [1:0] o, input logic sb);
        int unsigned ai = a;
        int unsigned bi = b;
        int unsigned raw;
        logic        c, h;
        logic [15:0] r;
        if (sb) begin
            raw = (ai - bi) & 32'hFFFF;
            c   = ai < bi;
            h   = (ai & 15) < (bi & 15);
        end else begin
            raw = (ai + bi) & 32'hFFFF;
            c   = (ai + bi) > 32'hFFFF;
            h   = ((ai & 15) + (bi & 15)) > 15;
        end
        r = raw[15:0];
        if (o == 2'b10) begin
            r[7:4] = 4'h0; c = cfi; h = afi;
        end else if (o == 2'b11) begin
            r[15:8] = a[15:8]; c = cfi; h = afi;
        end
        return {r, c, h, (r == 16'h0000), r[15]};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("result", {16'h0, result}, {16'h0, exp_v[19:4]});
            check("flags cf/af/zf/sf", {28'h0, cf_out, af_out, zf_out, sf_out}, {28'h0, exp_v[3:0]});
            check("in_ready in DONE", {31'h0, in_ready}, 32'h0);
        end
    end

    // Offer one op at a negedge; returns after the accepting edge, at the following negedge.
    task automatic offer(input logic [15:0] a, input logic [15:0] b, input logic cfi,
                         input logic afi, input logic [1:0] o, input logic sb);
        int k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk); k++;
        end
        check("in_ready before offer", {31'h0, in_ready}, 32'h1);
        a_in = a; b_in = b; cf_in = cfi; af_in = afi; op = o; sub = sb;
        in_valid = 1'b1;
        exp_v = model(a, b, cfi, afi, o, sb);
        @(negedge clk);
        in_valid = 1'b0;
        a_in = $urandom; b_in = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cfi, input logic afi, input logic [1:0] o,
                          input logic sb, input int hold);
        int k = 0;
        out_ready = (hold == 0);
        offer(a, b, cfi, afi, o, sb);
        while (!out_valid && k < 20) begin
            @(negedge clk); k++;
        end
        check({tag, " latency"}, k, LATENCY);
        for (int i = 0; i < hold; i++) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, " back to IDLE"}, {30'h0, out_valid, in_ready}, 32'h1);
    endtask

    initial begin
        // Pin the model with hand-worked values.
        check("model plain add", {12'h0, model(16'h1234, 16'h0FFF, 1'b0, 1'b0, 2'b00, 1'b0)}, {12'h0, 16'h2233, 4'b0100});
        check("model plain sub", {12'h0, model(16'h0000, 16'h0001, 1'b0, 1'b0, 2'b00, 1'b1)}, {12'h0, 16'hFFFF, 4'b1101});
        check("model AAA",       {12'h0, model(16'h000C, 16'h0106, 1'b1, 1'b1, 2'b10, 1'b0)}, {12'h0, 16'h0102, 4'b1100});
        check("model DAA wrap",  {12'h0, model(16'h009A, 16'h0066, 1'b1, 1'b1, 2'b11, 1'b0)}, {12'h0, 16'h0000, 4'b1110});

        repeat (2) @(negedge clk);
        check("reset in_ready", {31'h0, in_ready}, 32'h0);
        check("reset outputs", {11'h0, out_valid, result, cf_out, af_out, zf_out, sf_out}, 32'h0);
        rst = 1'b0;
        #1;
        check("in_ready after reset", {31'h0, in_ready}, 32'h1);
        @(negedge clk);

        run_op("plain add",  16'h1234, 16'h0FFF, 1'b0, 1'b0, 2'b00, 1'b0, 0);
        run_op("plain sub",  16'h0000, 16'h0001, 1'b0, 1'b0, 2'b00, 1'b1, 0);
        run_op("AAA",        16'h000C, 16'h0106, 1'b1, 1'b1, 2'b10, 1'b0, 0);
        run_op("DAA wrap",   16'h009A, 16'h0066, 1'b1, 1'b1, 2'b11, 1'b0, 0);
        run_op("add carry",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 2'b00, 1'b0, 0);
        run_op("op01 sub",   16'h8000, 16'h0001, 1'b1, 1'b0, 2'b01, 1'b1, 0);
        run_op("AAS",        16'h0205, 16'h0106, 1'b1, 1'b0, 2'b10, 1'b1, 0);
        run_op("DAS",        16'h1234, 16'h0066, 1'b0, 1'b1, 2'b11, 1'b1, 0);
        run_op("backpress",  16'hA5C3, 16'h1E2F, 1'b0, 1'b0, 2'b00, 1'b0, 3);

        // Reset while the second CALC cycle is pending.
        out_ready = 1'b1;
        offer(16'h4321, 16'h1111, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-op reset outputs", {11'h0, out_valid, result, cf_out, af_out, zf_out, sf_out}, 32'h0);
        check("mid-op reset in_ready", {31'h0, in_ready}, 32'h0);
        rst = 1'b0;
        #1;
        check("in_ready after mid-op reset", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        run_op("post-reset", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 2'b00, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/adjust_apply_unit.md
# adjust_apply_unit

Sequential arithmetic stage directly downstream of the ASCII/decimal adjust module. It consumes that module's operand A, correction/operand B, adjusted CF/AF and the adjust opcode, then applies the correction with a nibble-serial 16-bit adder/subtractor. It performs the post-adjust masking for AAA/AAS and the byte restriction for DAA/DAS, registers the result and flags, and returns them over a valid/ready handshake. For op=0x it acts as a plain 16-bit add/sub and generates its own CF/AF.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operation offered
- in_ready  out  1  unit can accept; high only in IDLE with rst low
- a_in  in  16  operand A (adjust module A output)
- b_in  in  16  operand B / correction constant (adjust module B output)
- cf_in  in  1  adjusted carry from adjust module
- af_in  in  1  adjusted auxiliary carry from adjust module
- op  in  2  00/01 plain, 10 ASCII adjust, 11 decimal adjust
- sub  in  1  0 = add (AAA/DAA), 1 = subtract (AAS/DAS)
- out_valid  out  1  result registered and held
- out_ready  in  1  downstream accepts result
- result  out  16  final value
- cf_out, af_out, zf_out, sf_out  out  1 each  carry, aux carry, zero, sign

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid, capture a_in, b_in, cf_in, af_in, op, sub. Clear the nibble counter to 0. Set carry-in to sub. Go to CALC.
- CALC: each cycle computes nibble n (bits 4n+3:4n): sum = A_n + (sub ? ~B_n : B_n) + carry. Stores 4 bits and carries forward. n counts 0..3. After n=3, go to DONE and register outputs.
- Arithmetic is modulo 2^16. In subtract mode, CF is borrow = NOT carry-out of bit 15, and AF is borrow = NOT carry-out of bit 3.
- Output shaping, applied when entering DONE:
  - op=0x: result = raw sum; cf_out/af_out from the adder.
  - op=10: result = raw sum with bits [7:4] forced to 0; cf_out=cf_in, af_out=af_in.
  - op=11: result = {a_in[15:8], raw[7:0]}; cf_out=cf_in, af_out=af_in.
- zf_out = (result==0); sf_out = result[15]. Both are computed on the shaped result.
- DONE: out_valid=1. result and flags are stable until out_ready=1; then go to IDLE. No new input is accepted in DONE.
- Reset values: result=0, all flags 0, out_valid=0, state IDLE, nibble counter 0. in_ready=0 while rst=1.
- Reset in CALC or DONE: partial result discarded, outputs return to reset values on the next edge, state IDLE.
- in_valid while busy: ignored (in_ready=0). No queuing.

## Timing
- Accept edge T. CALC runs on edges T+1..T+4. out_valid is high after edge T+4, so latency is 4 cycles.
- out_ready is sampled on the first DONE cycle. If high, DONE lasts one cycle and the unit is back in IDLE after edge T+5. Earliest next accept is edge T+6, giving a throughput of one op per 6 cycles.
- out_ready low holds DONE indefinitely with no output change.
- in_ready is combinational from state and rst. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- ADJ_SINGLE_CYCLE_EN defined: CALC is a single cycle computing the full 16-bit add/sub. Accept at edge T gives out_valid after edge T+1, and throughput is one op per 3 cycles. Flags and shaping are identical.
- Undefined (default): nibble-serial, 4-cycle CALC as above.

## Test plan
- Plain add: op=00, sub=0, a=0x1234, b=0x0FFF. Expect result=0x2233, cf=0, af=1, zf=0, sf=0, with out_valid exactly 4 cycles after accept.
- Plain sub: op=00, sub=1, a=0x0000, b=0x0001. Expect result=0xFFFF, cf=1, af=1, sf=1, zf=0.
- AAA: op=10, sub=0, a=0x000C, b=0x0106, cf_in=1, af_in=1. Expect raw 0x0112, result=0x0102, cf=1, af=1.
- DAA wrap: op=11, sub=0, a=0x009A, b=0x0066, cf_in=1, af_in=1. Expect result=0x0000, zf=1, cf=1, af=1, sf=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid. result and flags must not change and in_ready stays 0. Release; state is IDLE on the next edge.
- Reset mid-op: assert rst for 1 cycle at the 2nd CALC cycle. Next cycle: out_valid=0, result=0, flags 0. After rst drops, in_ready=1, and a fresh op completes correctly.
